// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin sharing of one external combinational ALU between
//             two valid/ready requesters. The ALU result is captured on the
//             request handshake and held until the owner drains it.
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [3:0]        req_op0,
   input  logic [3:0]        req_op1,
   input  logic [DATA_W-1:0] req_a0,
   input  logic [DATA_W-1:0] req_b0,
   input  logic [DATA_W-1:0] req_a1,
   input  logic [DATA_W-1:0] req_b1,
   output logic [1:0]        rsp_valid,
   input  logic [1:0]        rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [3:0]        alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   output logic [CNT_W-1:0]  ops_done
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   // Highest legal op code (PASS_B); anything above is reported as an error.
   localparam logic [3:0] OP_LAST = 4'd10;

   state_e              state_q;
   logic                owner_q;
   logic                ptr_q;
   logic [1:0]          rsp_valid_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic                rsp_err_q;
   logic [CNT_W-1:0]    ops_done_q;
   logic [CNT_W-1:0]    ops_done_d;

   logic                grant_ok;
   logic                grant;
   logic                win;
   logic [3:0]          win_op;
   logic [DATA_W-1:0]   win_a;
   logic [DATA_W-1:0]   win_b;
   logic                win_illegal;
   logic                rsp_hs;

   // Arbitration, ALU operand steering and response-handshake detection.
   always_comb begin
      // A held response blocks new grants unless its owner drains it this cycle.
      grant_ok = (state_q == IDLE) || rsp_ready[owner_q];

      case (req_valid)
         2'b01:   win = 1'b0;
         2'b10:   win = 1'b1;
         default: win = ptr_q;
      endcase

      // No handshake can complete while reset is asserted.
      grant = rst_n && grant_ok && (req_valid != 2'b00);

      req_ready = 2'b00;
      if (grant) begin
         req_ready[win] = 1'b1;
      end

      win_op      = win ? req_op1 : req_op0;
      win_a       = win ? req_a1  : req_a0;
      win_b       = win ? req_b1  : req_b0;
      win_illegal = (win_op > OP_LAST);

      // Quiet ALU inputs when nothing is being granted.
      alu_op = grant ? win_op : 4'd0;
      alu_a  = grant ? win_a  : '0;
      alu_b  = grant ? win_b  : '0;

      rsp_hs     = |(rsp_valid_q & rsp_ready);
      ops_done_d = rsp_hs ? (ops_done_q + CNT_W'(1)) : ops_done_q;
   end

   // Response holding FSM: capture on grant, release on owner drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         ptr_q       <= 1'b0;
         rsp_valid_q <= 2'b00;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         ops_done_q  <= '0;
      end else begin
         ops_done_q <= ops_done_d;
         if (grant) begin
            // New capture; also covers same-cycle drain-and-refill.
            state_q     <= HOLD;
            owner_q     <= win;
            ptr_q       <= ~win;
            rsp_valid_q <= win ? 2'b10 : 2'b01;
            rsp_data_q  <= win_illegal ? '0 : alu_result;
            rsp_err_q   <= win_illegal;
         end else if ((state_q == HOLD) && rsp_ready[owner_q]) begin
            // Drained with nothing behind it; data keeps its last value.
            state_q     <= IDLE;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign ops_done  = ops_done_q;

endmodule
`default_nettype wire
